// File: rtl/bus_master_arbiter.sv
// Two-requester arbiter/sequencer for the shared register bus: one transaction at a time.
// Build option: define BUS_ARB_FIXED_PRIO_EN for fixed m0-first priority (default is round-robin).
module bus_master_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_op,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rsp_valid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_op,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rsp_valid,
  output logic [DW-1:0] m1_rdata,
  output logic          bus_cmd_valid,
  output logic          bus_op,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wr_data,
  input  logic [DW-1:0] bus_rd_data
);

  localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_RSP} state_t;

  state_t         r_state, w_next;
  logic           r_owner;
  logic [LCW-1:0] r_lat_cnt;
  logic           w_any_req;
  logic           w_winner;
  logic           w_take;
  logic           w_owner_nxt;
  logic           w_cmd_valid, w_op;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_wdata;
  logic           w_m0_gnt, w_m1_gnt, w_m0_rsp, w_m1_rsp;
  logic [DW-1:0]  w_m0_rdata, w_m1_rdata;

  assign w_any_req = m0_req | m1_req;
  assign w_take    = (r_state == S_IDLE) && w_any_req;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign w_winner = ~m0_req;
`else
  logic r_rr_ptr;

  always_comb begin
    if (m0_req && m1_req) w_winner = r_rr_ptr;
    else                  w_winner = ~m0_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_rr_ptr <= 1'b0;
    else if (w_take) r_rr_ptr <= ~w_winner;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_CMD;
      S_CMD:   w_next = bus_op ? S_RSP : S_WAIT;
      S_WAIT:  if (r_lat_cnt == '0) w_next = S_RSP;
      S_RSP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that their registered copies line up with the state.
  always_comb begin
    w_owner_nxt = w_take ? w_winner : r_owner;
    w_op        = bus_op;
    w_addr      = bus_addr;
    w_wdata     = bus_wr_data;
    if (w_take) begin
      w_op    = w_winner ? m1_op    : m0_op;
      w_addr  = w_winner ? m1_addr  : m0_addr;
      w_wdata = w_winner ? m1_wdata : m0_wdata;
    end
    w_cmd_valid = (w_next == S_CMD);
    w_m0_gnt    = w_cmd_valid && !w_owner_nxt;
    w_m1_gnt    = w_cmd_valid &&  w_owner_nxt;
    w_m0_rsp    = (w_next == S_RSP) && !w_owner_nxt;
    w_m1_rsp    = (w_next == S_RSP) &&  w_owner_nxt;
    w_m0_rdata  = '0;
    w_m1_rdata  = '0;
    if ((w_next == S_RSP) && (r_state == S_WAIT)) begin
      if (r_owner) w_m1_rdata = bus_rd_data;
      else         w_m0_rdata = bus_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner       <= 1'b0;
      r_lat_cnt     <= '0;
      bus_cmd_valid <= 1'b0;
      bus_op        <= 1'b0;
      bus_addr      <= '0;
      bus_wr_data   <= '0;
      m0_gnt        <= 1'b0;
      m1_gnt        <= 1'b0;
      m0_rsp_valid  <= 1'b0;
      m1_rsp_valid  <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
    end else begin
      r_owner       <= w_owner_nxt;
      if (r_state == S_CMD)                          r_lat_cnt <= LCW'(RD_LAT - 1);
      else if (r_state == S_WAIT && r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - 1'b1;
      bus_cmd_valid <= w_cmd_valid;
      bus_op        <= w_op;
      bus_addr      <= w_addr;
      bus_wr_data   <= w_wdata;
      m0_gnt        <= w_m0_gnt;
      m1_gnt        <= w_m1_gnt;
      m0_rsp_valid  <= w_m0_rsp;
      m1_rsp_valid  <= w_m1_rsp;
      m0_rdata      <= w_m0_rdata;
      m1_rdata      <= w_m1_rdata;
    end
  end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 16-bit register bus (bus_cmd_valid / bus_op / bus_addr / bus_wr_data / bus_rd_data).
- Lets a config sequencer (m0) and a debug/host port (m1) access bus registers, e.g. the invert control at address 0x9.
- Serializes accesses, drives single-cycle bus commands, waits the slave read latency, and returns a response to the owning requester.

Parameters:
- AW, 16, bus address width
- DW, 16, bus data width
- RD_LAT, 1, cycles from the bus command cycle to bus_rd_data valid (≥1)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- m0_req  input  1  requester 0 access request; held until m0_gnt
- m0_op  input  1  1=write, 0=read
- m0_addr  input  AW  access address
- m0_wdata  input  DW  write data
- m0_gnt  output  1  one-cycle accept pulse
- m0_rsp_valid  output  1  one-cycle completion pulse
- m0_rdata  output  DW  read data, valid with m0_rsp_valid
- m1_req, m1_op, m1_addr, m1_wdata, m1_gnt, m1_rsp_valid, m1_rdata: same as m0_* for requester 1
- bus_cmd_valid  output  1  bus command strobe
- bus_op  output  1  1=write, 0=read
- bus_addr  output  AW  bus address
- bus_wr_data  output  DW  bus write data
- bus_rd_data  input  DW  slave read data, registered in the slave

Behaviour:
- All outputs are registered. Reset values: all outputs 0; state IDLE; rr_ptr=0 (m0 preferred).
- FSM states: IDLE, CMD, WAIT, RSP.
- IDLE:
  - If either req is high, select a winner, latch its op/addr/wdata and the owner id, then go to CMD.
  - Requesters must hold op/addr/wdata stable while req is high.
- CMD (1 cycle):
  - bus_cmd_valid=1; bus_op/addr/wr_data show the latched values.
  - Owner's mX_gnt=1 in this same cycle; the requester drops or advances req on gnt.
  - Write: go to RSP. Read: go to WAIT and load lat_cnt=RD_LAT-1.
- WAIT:
  - bus_cmd_valid=0.
  - When lat_cnt==0, capture bus_rd_data into rdata_q and go to RSP; otherwise decrement lat_cnt.
  - With RD_LAT=1, WAIT lasts exactly 1 cycle, i.e. the cycle after CMD.
- RSP (1 cycle):
  - Owner's mX_rsp_valid=1; mX_rdata=rdata_q for reads, 0 for writes.
  - Non-owner rsp_valid=0 and rdata=0. Then go to IDLE.
- Latency, counted from the first IDLE cycle with req high:
  - gnt appears after 1 cycle.
  - Write rsp_valid appears after 2 cycles; write transaction occupies 3 cycles.
  - Read rsp_valid appears after 2+RD_LAT cycles; read occupies 3+RD_LAT cycles.
- Outstanding transactions: exactly one at a time. Requests arriving outside IDLE wait; no request is lost.
- Arbitration:
  - Round-robin. On a grant, rr_ptr = the other requester.
  - When both request in IDLE, the requester pointed to by rr_ptr wins. A single requester always wins.
- Bus fields: bus_op/addr/wr_data keep their last latched values outside CMD. Only bus_cmd_valid qualifies them.
- Req deasserted after latching (in CMD/WAIT/RSP): the transaction still completes and the response is still delivered.
- Reset asserted mid-transaction: abort immediately. On the next cycle all outputs are 0, state is IDLE, rr_ptr=0, and no gnt or rsp is issued for the aborted access.
- Widths: addresses and data pass through unmodified. No arithmetic except the lat_cnt countdown, which is sized to hold RD_LAT.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 always wins a simultaneous request, and rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.
- Latency, FSM and response behaviour are identical in both builds.

Test Plan:
- Reset, then m0 write addr=0x9 data=0x0001 → cycle+1: m0_gnt=1 with bus_cmd_valid=1, bus_op=1, bus_addr=0x9, bus_wr_data=0x1; cycle+2: m0_rsp_valid=1, m0_rdata=0; invert path active (rxd=0x5A gives txd=0xA5).
- m1 read addr=0x9 after that write → m1_rsp_valid at cycle+3 with m1_rdata=0x0001; read addr=0x3 → m1_rdata=0x0000.
- m0 and m1 both request writes at the same cycle after reset → m0 granted first, then m1; repeat with both held → grants alternate m0,m1,m0,m1. With BUS_ARB_FIXED_PRIO_EN: m0,m0,... until m0 drops req.
- Back-to-back m0 reads with req held → one transaction per 4 cycles (RD_LAT=1); bus_cmd_valid never asserted on consecutive cycles; no responses delivered to m1.
- rst_n low during WAIT of an m1 read → next cycle all outputs 0; no m1_rsp_valid ever; a subsequent m1 request completes normally.
- m0 drops req the cycle after m0_gnt → m0_rsp_valid still issued; no second bus command.
